// File: rtl/wb_timer.sv
// wb_timer: Wishbone-mapped down-counting timer with sticky timeout, continuous mode and level interrupt.
module wb_timer #(
  parameter int PERIOD_WIDTH = 32,
  parameter int RESET_PERIOD = 20
) (
  input  logic        clk_i,
  input  logic        reset_n,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        intr_o
);
  localparam int W = PERIOD_WIDTH;
  logic [W-1:0] period, cnt;
  logic run, to, ito, cont;
  logic acc, wr, ctl, start, stop, expire, clr;
  logic [1:0] a;
  logic [31:0] p32, pm, rd;
  logic unused;
  assign unused = &{1'b0, wb_adr_i[1:0]};
  always_comb begin
    acc = wb_stb_i & wb_cyc_i & !wb_ack_o;
    wr = acc & wb_we_i;
    a = wb_adr_i[3:2];
    ctl = wr & (a == 2'd1) & wb_sel_i[0];
    stop = ctl & wb_dat_i[3];
    start = ctl & wb_dat_i[2] & !wb_dat_i[3];
    clr = wr & (a == 2'd0) & wb_sel_i[0];
    expire = run & !start & !stop & (cnt <= W'(1));
    p32 = 32'(period);
    pm = p32;
    for (int i = 0; i < 4; i++) pm[i*8+:8] = wb_sel_i[i] ? wb_dat_i[i*8+:8] : p32[i*8+:8];
    rd = a == 2'd0 ? {30'd0, run, to} : a == 2'd1 ? {30'd0, cont, ito} : a == 2'd2 ? p32 : 32'(cnt);
  end
  // Reads return pre-edge contents; expiry beats a same-edge STATUS clear.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      period <= W'(RESET_PERIOD);
      cnt <= '0;
      run <= 1'b0;
      to <= 1'b0;
      ito <= 1'b0;
      cont <= 1'b0;
    end else begin
      wb_ack_o <= acc;
      wb_dat_o <= (acc & !wb_we_i) ? rd : '0;
      if (clr) to <= 1'b0;
      if (expire) to <= 1'b1;
      if (ctl) begin
        ito <= wb_dat_i[0];
        cont <= wb_dat_i[1];
      end
      if (wr & (a == 2'd2)) period <= pm[W-1:0];
      if (stop) run <= 1'b0;
      else if (start) begin
        cnt <= period;
        run <= 1'b1;
      end else if (expire) begin
        cnt <= cont ? period : '0;
        run <= cont;
      end else if (run) cnt <= cnt - W'(1);
    end
  end
  assign intr_o = to & ito;
endmodule

// File: doc/wb_timer.md
WB_TIMER -- requirements
Module: wb_timer

Interface
REQ-001 SHALL have parameter PERIOD_WIDTH, default 32, counter and PERIOD register width (1..32).
REQ-002 SHALL have parameter RESET_PERIOD, default 20, PERIOD register value after reset.
REQ-003 SHALL have port clk_i  in  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port wb_adr_i  in  4  byte address; bits [3:2] select register, [1:0] ignored.
REQ-006 SHALL have port wb_dat_i  in  32  write data.
REQ-007 SHALL have port wb_sel_i  in  4  byte lane enables for writes.
REQ-008 SHALL have port wb_we_i  in  1  1 = write, 0 = read.
REQ-009 SHALL have port wb_stb_i / wb_cyc_i  in  1 each  Wishbone strobe and cycle.
REQ-010 SHALL have port wb_dat_o  out  32  registered read data, valid while wb_ack_o = 1.
REQ-011 SHALL have port wb_ack_o  out  1  registered single-cycle acknowledge.
REQ-012 SHALL have port intr_o  out  1  level interrupt to the CPU.

Function
REQ-013 Register map SHALL be: 0x0 STATUS (bit0 TO sticky, bit1 RUN read-only); 0x4 CONTROL (bit0 ITO, bit1 CONT, bit2 START write-only, bit3 STOP write-only); 0x8 PERIOD RW; 0xC SNAPSHOT RO current counter.
REQ-014 Unused bits SHALL read 0; PERIOD and SNAPSHOT SHALL be zero-extended to 32 bits; START/STOP SHALL read 0.
REQ-015 Access SHALL be accepted at edge T when wb_stb_i & wb_cyc_i & !wb_ack_o; wb_ack_o SHALL be 1 for exactly the cycle after T, then 0 (at most one ack per two cycles).
REQ-016 Write side effects SHALL take place at edge T; a read SHALL capture register contents as of edge T.
REQ-017 A write to STATUS with wb_sel_i[0]=1 SHALL clear TO; RUN SHALL be unaffected.
REQ-018 CONTROL writes SHALL require wb_sel_i[0]=1; PERIOD writes SHALL update only the byte lanes enabled by wb_sel_i; SNAPSHOT writes SHALL be acked and ignored.
REQ-019 START=1 SHALL load the counter with PERIOD and set RUN at edge T; STOP=1 SHALL clear RUN at edge T and freeze the counter; START and STOP written together SHALL act as STOP.
REQ-020 While RUN=1 at a clock edge with no START/STOP write: counter > 1 SHALL decrement by 1; counter <= 1 SHALL expire.
REQ-021 Expiry SHALL set TO; with CONT=1 it SHALL reload PERIOD and keep RUN=1; with CONT=0 it SHALL load 0 and clear RUN.
REQ-022 With PERIOD=N (N>=1) and START at edge T, TO SHALL first be 1 after edge T+N; in CONT mode it SHALL re-expire every N cycles; PERIOD=0 SHALL behave as PERIOD=1.
REQ-023 A PERIOD write while running SHALL not alter the current count; it SHALL apply at the next START or reload.
REQ-024 When a STATUS clear and an expiry occur at the same edge, TO SHALL end set.
REQ-025 START while running SHALL restart the count from PERIOD.
REQ-026 intr_o SHALL equal TO & ITO, driven from registers only, with no combinational path from bus inputs.
REQ-027 wb_cyc_i or wb_stb_i dropping before ack SHALL produce no ack and no side effect.

Reset
REQ-028 reset_n low SHALL immediately force counter=0, RUN=0, TO=0, ITO=0, CONT=0, PERIOD=RESET_PERIOD, wb_ack_o=0, wb_dat_o=0, intr_o=0.
REQ-029 Reset asserted mid-transaction or mid-count SHALL abandon it; after release, no ack SHALL be issued until a new strobe.

Verification
REQ-030 Write PERIOD=5, CONTROL=0x5 (ITO|START) -> RUN=1, SNAPSHOT reads 4..2 descending, TO=1 and intr_o=1 five cycles after START edge, then RUN=0.
REQ-031 PERIOD=3, CONTROL=0x7 (continuous) -> TO re-sets every 3 cycles; STATUS clear each time leaves intr_o low 2 cycles and high again; CONTROL=0x8 stops and freezes SNAPSHOT.
REQ-032 STATUS clear issued on the exact expiry edge -> STATUS reads TO=1.
REQ-033 Write 0xAABBCCDD to PERIOD with wb_sel_i=0x3 after reset (PERIOD=20) -> PERIOD reads 0x0000CCDD; CONTROL=0xC -> RUN stays 0.
REQ-034 Assert reset_n low for 1 cycle while counting and during a pending access -> all outputs 0, PERIOD=20, no ack after release.
REQ-035 Hold wb_stb_i & wb_cyc_i high for 6 cycles -> wb_ack_o pattern 0,1,0,1,0,1.
